// File: rtl/wasm_frame_ctrl_if.sv
// Issue-stage and operand-stack signal bundle for wasm_frame_ctrl.
// The issue stage uses the master modport and the frame controller uses the slave modport.
interface wasm_frame_ctrl_if #(
  parameter int ST_WIDTH      = 64,
  parameter int ST_LOG2_DEPTH = 8,
  parameter int FRAME_DEPTH   = 16,
  parameter int PC_W          = 16
);
  localparam int PW  = ST_LOG2_DEPTH + 1;
  localparam int FCW = $clog2(FRAME_DEPTH) + 1;

  // Issue side
  logic                     call_req;
  logic [7:0]               call_param_num;
  logic [7:0]               call_local_num;
  logic                     call_result_num;
  logic [PC_W-1:0]          call_target_pc;
  logic [PC_W-1:0]          call_return_pc;
  logic                     ret_req;
  logic                     core_push_num;
  logic [3:0]               core_pop_num;
  logic [ST_WIDTH-1:0]      core_push_data;
  logic [7:0]               loc_idx;
  logic                     loc_we;
  logic [ST_WIDTH-1:0]      loc_wdata;
  logic                     ready;
  logic                     call_ack;
  logic                     pc_load;
  logic [PC_W-1:0]          pc_load_value;
  logic [PW-1:0]            frame_base;
  logic [FCW-1:0]           frame_cnt;
  logic                     trap;
  logic [1:0]               trap_code;
  logic [1:0]               dbg_state;
  // Operand stack side
  logic [PW-1:0]            st_top_pointer;
  logic [ST_WIDTH-1:0]      st_pop_window_a;
  logic                     st_call;
  logic                     st_return;
  logic [7:0]               st_alloc_size;
  logic [ST_LOG2_DEPTH-1:0] st_tag;
  logic                     st_push_num;
  logic [3:0]               st_pop_num;
  logic [ST_WIDTH-1:0]      st_push_data;
  logic                     st_local_set;
  logic [PW-1:0]            st_l_addr;
  logic [ST_WIDTH-1:0]      st_local_set_data;

  modport master (
    output call_req, call_param_num, call_local_num, call_result_num, call_target_pc,
           call_return_pc, ret_req, core_push_num, core_pop_num, core_push_data,
           loc_idx, loc_we, loc_wdata, st_top_pointer, st_pop_window_a,
    input  ready, call_ack, pc_load, pc_load_value, frame_base, frame_cnt, trap, trap_code,
           dbg_state, st_call, st_return, st_alloc_size, st_tag, st_push_num, st_pop_num,
           st_push_data, st_local_set, st_l_addr, st_local_set_data
  );

  modport slave (
    input  call_req, call_param_num, call_local_num, call_result_num, call_target_pc,
           call_return_pc, ret_req, core_push_num, core_pop_num, core_push_data,
           loc_idx, loc_we, loc_wdata, st_top_pointer, st_pop_window_a,
    output ready, call_ack, pc_load, pc_load_value, frame_base, frame_cnt, trap, trap_code,
           dbg_state, st_call, st_return, st_alloc_size, st_tag, st_push_num, st_pop_num,
           st_push_data, st_local_set, st_l_addr, st_local_set_data
  );
endinterface

// File: rtl/wasm_frame_ctrl.sv
// Call/return frame controller in front of the operand stack. Define WASM_FRAME_ZERO_INIT_EN
// to zero-initialise newly allocated locals (ZERO state); otherwise they keep stale contents.
// Handshake: a request is taken only in a cycle where ready=1; a call is accepted exactly when
// call_ack=1, a return whenever ret_req=1 with ready=1, and core ops in those cycles are dropped.
module wasm_frame_ctrl #(
  parameter int ST_WIDTH      = 64,
  parameter int ST_LOG2_DEPTH = 8,
  parameter int FRAME_DEPTH   = 16,
  parameter int PC_W          = 16
) (
  input logic              clk,
  input logic              rst_n,
  wasm_frame_ctrl_if.slave bus
);
  localparam int PW = ST_LOG2_DEPTH + 1;
  localparam int FW = $clog2(FRAME_DEPTH);
  localparam logic [PW:0]   ST_SIZE_W  = {2'b01, {ST_LOG2_DEPTH{1'b0}}};
  localparam logic [PW-1:0] ST_SIZE_P  = {1'b1, {ST_LOG2_DEPTH{1'b0}}};
  localparam logic [FW:0]   FRAME_FULL = {1'b1, {FW{1'b0}}};
  localparam logic [1:0] TC_FRAME_OVF   = 2'd1;
  localparam logic [1:0] TC_RET_EMPTY   = 2'd2;
  localparam logic [1:0] TC_STACK_RANGE = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ZERO = 2'd1, S_TRAP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [FW:0]     frame_cnt_q;
  logic [PW-1:0]   frame_base_q;
  logic            trap_q;
  logic [1:0]      trap_code_q, trap_code_d;
  logic            pc_load_q;
  logic [PC_W-1:0] pc_load_value_q;
  logic            do_call, do_ret, trap_set;

  logic [PC_W-1:0] ret_pc_mem [FRAME_DEPTH];
  logic [PW-1:0]   base_mem   [FRAME_DEPTH];
  logic            res_mem    [FRAME_DEPTH];

`ifdef WASM_FRAME_ZERO_INIT_EN
  logic [7:0]      zero_k_q, zero_n_q;
  logic [PW-1:0]   zero_base_q;
`endif

  logic [PW-1:0] call_base;
  logic [PW:0]   call_end;
  logic [FW:0]   cnt_m1, cnt_m2;

  assign call_base = bus.st_top_pointer - PW'(bus.call_param_num);
  assign call_end  = {1'b0, bus.st_top_pointer} + (PW+1)'(bus.call_local_num);
  assign cnt_m1    = frame_cnt_q - (FW+1)'(1);
  assign cnt_m2    = frame_cnt_q - (FW+1)'(2);

  always_comb begin
    state_d               = state_q;
    do_call               = 1'b0;
    do_ret                = 1'b0;
    trap_set              = 1'b0;
    trap_code_d           = trap_code_q;
    bus.ready             = 1'b0;
    bus.call_ack          = 1'b0;
    bus.st_call           = 1'b0;
    bus.st_return         = 1'b0;
    bus.st_alloc_size     = 8'd0;
    bus.st_tag            = '0;
    bus.st_push_num       = 1'b0;
    bus.st_pop_num        = 4'd0;
    bus.st_push_data      = '0;
    bus.st_local_set      = 1'b0;
    bus.st_l_addr         = frame_base_q + PW'(bus.loc_idx);
    bus.st_local_set_data = '0;
    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.ret_req) begin
          // Return has priority over a simultaneous call; the call must be re-issued.
          if (frame_cnt_q == '0) begin
            trap_set    = 1'b1;
            trap_code_d = TC_RET_EMPTY;
            state_d     = S_TRAP;
          end else begin
            do_ret           = 1'b1;
            bus.st_return    = 1'b1;
            bus.st_tag       = base_mem[cnt_m1[FW-1:0]][ST_LOG2_DEPTH-1:0];
            bus.st_push_num  = res_mem[cnt_m1[FW-1:0]];
            bus.st_push_data = bus.st_pop_window_a;
          end
        end else if (bus.call_req) begin
          if (frame_cnt_q == FRAME_FULL) begin
            trap_set    = 1'b1;
            trap_code_d = TC_FRAME_OVF;
            state_d     = S_TRAP;
          end else if ((bus.st_top_pointer < PW'(bus.call_param_num)) ||
                       (call_end > ST_SIZE_W) || (call_base == ST_SIZE_P)) begin
            trap_set    = 1'b1;
            trap_code_d = TC_STACK_RANGE;
            state_d     = S_TRAP;
          end else begin
            do_call           = 1'b1;
            bus.call_ack      = 1'b1;
            bus.st_call       = 1'b1;
            bus.st_alloc_size = bus.call_local_num;
`ifdef WASM_FRAME_ZERO_INIT_EN
            if (bus.call_local_num != 8'd0) state_d = S_ZERO;
`endif
          end
        end else begin
          bus.st_push_num       = bus.core_push_num;
          bus.st_pop_num        = bus.core_pop_num;
          bus.st_push_data      = bus.core_push_data;
          bus.st_local_set      = bus.loc_we;
          bus.st_local_set_data = bus.loc_wdata;
        end
      end
`ifdef WASM_FRAME_ZERO_INIT_EN
      S_ZERO: begin
        bus.st_local_set = 1'b1;
        bus.st_l_addr    = zero_base_q + PW'(zero_k_q);
        if (zero_k_q == zero_n_q - 8'd1) state_d = S_IDLE;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      frame_cnt_q     <= '0;
      frame_base_q    <= '0;
      trap_q          <= 1'b0;
      trap_code_q     <= 2'd0;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= '0;
`ifdef WASM_FRAME_ZERO_INIT_EN
      zero_k_q        <= 8'd0;
      zero_n_q        <= 8'd0;
      zero_base_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_load_q <= 1'b0;
      if (trap_set) begin
        trap_q      <= 1'b1;
        trap_code_q <= trap_code_d;
      end
      if (do_call) begin
        frame_cnt_q     <= frame_cnt_q + (FW+1)'(1);
        frame_base_q    <= call_base;
        pc_load_q       <= 1'b1;
        pc_load_value_q <= bus.call_target_pc;
`ifdef WASM_FRAME_ZERO_INIT_EN
        zero_k_q        <= 8'd0;
        zero_n_q        <= bus.call_local_num;
        zero_base_q     <= bus.st_top_pointer;
`endif
      end
      if (do_ret) begin
        frame_cnt_q     <= cnt_m1;
        frame_base_q    <= (frame_cnt_q > (FW+1)'(1)) ? base_mem[cnt_m2[FW-1:0]] : '0;
        pc_load_q       <= 1'b1;
        pc_load_value_q <= ret_pc_mem[cnt_m1[FW-1:0]];
      end
`ifdef WASM_FRAME_ZERO_INIT_EN
      if (state_q == S_ZERO) zero_k_q <= zero_k_q + 8'd1;
`endif
    end
  end

  // Frame storage needs no reset: frame_cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_call) begin
      ret_pc_mem[frame_cnt_q[FW-1:0]] <= bus.call_return_pc;
      base_mem[frame_cnt_q[FW-1:0]]   <= call_base;
      res_mem[frame_cnt_q[FW-1:0]]    <= bus.call_result_num;
    end
  end

  assign bus.pc_load       = pc_load_q;
  assign bus.pc_load_value = pc_load_value_q;
  assign bus.frame_base    = frame_base_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.trap          = trap_q;
  assign bus.trap_code     = trap_code_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_wasm_frame_ctrl.sv
// Directed bench for wasm_frame_ctrl: calls, returns, zero-init (when WASM_FRAME_ZERO_INIT_EN),
// trap causes and passthrough. Inputs change 1ns after posedge; outputs sampled 2ns later.
module tb_wasm_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wasm_frame_ctrl_if bus ();
  wasm_frame_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic idle_inputs();
    bus.call_req = 0; bus.call_param_num = 0; bus.call_local_num = 0; bus.call_result_num = 0;
    bus.call_target_pc = 0; bus.call_return_pc = 0; bus.ret_req = 0;
    bus.core_push_num = 0; bus.core_pop_num = 0; bus.core_push_data = 0;
    bus.loc_idx = 0; bus.loc_we = 0; bus.loc_wdata = 0;
    bus.st_top_pointer = 0; bus.st_pop_window_a = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_call(input logic [8:0] top, input logic [7:0] pn, input logic [7:0] ln,
                            input logic res, input logic [15:0] tgt, input logic [15:0] rpc);
    bus.call_req = 1; bus.st_top_pointer = top; bus.call_param_num = pn; bus.call_local_num = ln;
    bus.call_result_num = res; bus.call_target_pc = tgt; bus.call_return_pc = rpc;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 20) begin step(); n++; end
    checks++;
    if (bus.ready !== 1'b1) begin failures++; $display("FAIL wait_ready timeout ready=%b want 1", bus.ready); end
  endtask

  task automatic test_reset();
    do_reset(); #2;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    checks++; if (bus.frame_cnt !== 5'd0) begin failures++; $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt); end
    checks++; if (bus.frame_base !== 9'd0) begin failures++; $display("FAIL reset_frame_base got %0d want 0", bus.frame_base); end
    checks++; if (bus.trap !== 1'b0) begin failures++; $display("FAIL reset_trap got %b want 0", bus.trap); end
    checks++; if (bus.trap_code !== 2'd0) begin failures++; $display("FAIL reset_trap_code got %0d want 0", bus.trap_code); end
    checks++; if (bus.pc_load !== 1'b0) begin failures++; $display("FAIL reset_pc_load got %b want 0", bus.pc_load); end
    checks++; if ({bus.st_call, bus.st_return, bus.st_local_set} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got %b want 000", {bus.st_call, bus.st_return, bus.st_local_set}); end
    step();
  endtask

  task automatic test_passthrough();
    bus.core_push_num = 1; bus.core_pop_num = 3; bus.core_push_data = 64'h55;
    bus.loc_idx = 4; bus.loc_we = 1; bus.loc_wdata = 64'h99;
    #2;
    checks++; if (bus.st_push_num !== 1'b1) begin failures++; $display("FAIL pass_push_num got %b want 1", bus.st_push_num); end
    checks++; if (bus.st_pop_num !== 4'd3) begin failures++; $display("FAIL pass_pop_num got %0d want 3", bus.st_pop_num); end
    checks++; if (bus.st_push_data !== 64'h55) begin failures++; $display("FAIL pass_push_data got %0h want 55", bus.st_push_data); end
    checks++; if (bus.st_local_set !== 1'b1) begin failures++; $display("FAIL pass_local_set got %b want 1", bus.st_local_set); end
    checks++; if (bus.st_l_addr !== 9'd4) begin failures++; $display("FAIL pass_l_addr got %0d want 4", bus.st_l_addr); end
    checks++; if (bus.st_local_set_data !== 64'h99) begin failures++; $display("FAIL pass_local_data got %0h want 99", bus.st_local_set_data); end
    step(); idle_inputs();
  endtask

  task automatic test_call_zero();
    drive_call(9'd5, 8'd2, 8'd3, 1'b1, 16'h40, 16'h10);
    bus.core_push_num = 1; bus.core_pop_num = 2;
    #2;
    checks++; if (bus.call_ack !== 1'b1) begin failures++; $display("FAIL call_ack got %b want 1", bus.call_ack); end
    checks++; if (bus.st_call !== 1'b1) begin failures++; $display("FAIL call_st_call got %b want 1", bus.st_call); end
    checks++; if (bus.st_alloc_size !== 8'd3) begin failures++; $display("FAIL call_alloc got %0d want 3", bus.st_alloc_size); end
    checks++; if ({bus.st_push_num, bus.st_pop_num} !== 5'd0) begin
      failures++; $display("FAIL call_core_dropped got push=%b pop=%0d want 0/0", bus.st_push_num, bus.st_pop_num); end
    step(); idle_inputs();
    bus.st_top_pointer = 9'd8;
    #2;
    checks++; if (bus.pc_load !== 1'b1) begin failures++; $display("FAIL call_pc_load got %b want 1", bus.pc_load); end
    checks++; if (bus.pc_load_value !== 16'h40) begin failures++; $display("FAIL call_pc_value got %0h want 40", bus.pc_load_value); end
    checks++; if (bus.frame_base !== 9'd3) begin failures++; $display("FAIL call_frame_base got %0d want 3", bus.frame_base); end
    checks++; if (bus.frame_cnt !== 5'd1) begin failures++; $display("FAIL call_frame_cnt got %0d want 1", bus.frame_cnt); end
`ifdef WASM_FRAME_ZERO_INIT_EN
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL zero_ready k=%0d got %b want 0", k, bus.ready); end
      checks++; if (bus.st_local_set !== 1'b1) begin failures++; $display("FAIL zero_set k=%0d got %b want 1", k, bus.st_local_set); end
      checks++; if (bus.st_l_addr !== 9'(5 + k)) begin failures++; $display("FAIL zero_addr k=%0d got %0d want %0d", k, bus.st_l_addr, 5 + k); end
      checks++; if (bus.st_local_set_data !== 64'd0) begin failures++; $display("FAIL zero_data k=%0d got %0h want 0", k, bus.st_local_set_data); end
      step(); #1;
    end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL zero_ready_back got %b want 1", bus.ready); end
`else
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL nozero_ready got %b want 1", bus.ready); end
    checks++; if (bus.st_local_set !== 1'b0) begin failures++; $display("FAIL nozero_local_set got %b want 0", bus.st_local_set); end
`endif
    bus.loc_idx = 8'd1; bus.loc_we = 1;
    #1;
    checks++; if (bus.st_l_addr !== 9'd4) begin failures++; $display("FAIL frame_rel_addr got %0d want 4", bus.st_l_addr); end
    step(); idle_inputs();
  endtask

  task automatic test_return();
    bus.st_pop_window_a = 64'h2A; bus.ret_req = 1;
    #2;
    checks++; if (bus.st_return !== 1'b1) begin failures++; $display("FAIL ret_st_return got %b want 1", bus.st_return); end
    checks++; if (bus.st_tag !== 8'd3) begin failures++; $display("FAIL ret_tag got %0d want 3", bus.st_tag); end
    checks++; if (bus.st_push_num !== 1'b1) begin failures++; $display("FAIL ret_push_num got %b want 1", bus.st_push_num); end
    checks++; if (bus.st_push_data !== 64'h2A) begin failures++; $display("FAIL ret_push_data got %0h want 2a", bus.st_push_data); end
    step(); idle_inputs(); #2;
    checks++; if (bus.pc_load !== 1'b1) begin failures++; $display("FAIL ret_pc_load got %b want 1", bus.pc_load); end
    checks++; if (bus.pc_load_value !== 16'h10) begin failures++; $display("FAIL ret_pc_value got %0h want 10", bus.pc_load_value); end
    checks++; if (bus.frame_cnt !== 5'd0) begin failures++; $display("FAIL ret_frame_cnt got %0d want 0", bus.frame_cnt); end
    checks++; if (bus.frame_base !== 9'd0) begin failures++; $display("FAIL ret_frame_base got %0d want 0", bus.frame_base); end
    step(); #2;
    checks++; if (bus.pc_load !== 1'b0) begin failures++; $display("FAIL ret_pc_load_pulse got %b want 0", bus.pc_load); end
  endtask

  task automatic test_back_to_back();
    drive_call(9'd10, 8'd1, 8'd0, 1'b0, 16'h100, 16'h21);
    step();
    drive_call(9'd20, 8'd2, 8'd0, 1'b1, 16'h200, 16'h22);
    step(); idle_inputs(); #2;
    checks++; if (bus.frame_base !== 9'd18) begin failures++; $display("FAIL b2b_frame_base got %0d want 18", bus.frame_base); end
    checks++; if (bus.frame_cnt !== 5'd2) begin failures++; $display("FAIL b2b_frame_cnt got %0d want 2", bus.frame_cnt); end
    drive_call(9'd20, 8'd0, 8'd0, 1'b0, 16'h300, 16'h23);
    bus.ret_req = 1; bus.st_pop_window_a = 64'h77;
    #1;
    checks++; if (bus.call_ack !== 1'b0) begin failures++; $display("FAIL both_call_ack got %b want 0", bus.call_ack); end
    checks++; if (bus.st_call !== 1'b0) begin failures++; $display("FAIL both_st_call got %b want 0", bus.st_call); end
    checks++; if (bus.st_return !== 1'b1) begin failures++; $display("FAIL both_st_return got %b want 1", bus.st_return); end
    checks++; if (bus.st_tag !== 8'd18) begin failures++; $display("FAIL both_tag got %0d want 18", bus.st_tag); end
    checks++; if (bus.st_push_num !== 1'b1) begin failures++; $display("FAIL both_push_num got %b want 1", bus.st_push_num); end
    step(); idle_inputs(); #2;
    checks++; if (bus.frame_base !== 9'd9) begin failures++; $display("FAIL both_frame_base got %0d want 9", bus.frame_base); end
    checks++; if (bus.frame_cnt !== 5'd1) begin failures++; $display("FAIL both_frame_cnt got %0d want 1", bus.frame_cnt); end
    checks++; if (bus.pc_load_value !== 16'h22) begin failures++; $display("FAIL both_pc_value got %0h want 22", bus.pc_load_value); end
    bus.ret_req = 1;
    #1;
    checks++; if (bus.st_tag !== 8'd9) begin failures++; $display("FAIL ret2_tag got %0d want 9", bus.st_tag); end
    checks++; if (bus.st_push_num !== 1'b0) begin failures++; $display("FAIL ret2_push_num got %b want 0", bus.st_push_num); end
    step(); idle_inputs(); #2;
    checks++; if (bus.frame_base !== 9'd0) begin failures++; $display("FAIL ret2_frame_base got %0d want 0", bus.frame_base); end
    checks++; if (bus.pc_load_value !== 16'h21) begin failures++; $display("FAIL ret2_pc_value got %0h want 21", bus.pc_load_value); end
    step();
  endtask

  task automatic test_ret_empty();
    do_reset();
    bus.ret_req = 1;
    #2;
    checks++; if (bus.st_return !== 1'b0) begin failures++; $display("FAIL empty_st_return got %b want 0", bus.st_return); end
    step(); idle_inputs(); #2;
    checks++; if (bus.trap !== 1'b1) begin failures++; $display("FAIL empty_trap got %b want 1", bus.trap); end
    checks++; if (bus.trap_code !== 2'd2) begin failures++; $display("FAIL empty_code got %0d want 2", bus.trap_code); end
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL empty_ready got %b want 0", bus.ready); end
    checks++; if (bus.dbg_state !== 2'd2) begin failures++; $display("FAIL empty_state got %0d want 2", bus.dbg_state); end
    drive_call(9'd5, 8'd0, 8'd0, 1'b0, 16'h1, 16'h2);
    #1;
    checks++; if ({bus.call_ack, bus.st_call} !== 2'b00) begin
      failures++; $display("FAIL trap_call_blocked got %b want 00", {bus.call_ack, bus.st_call}); end
    step(); idle_inputs();
  endtask

  task automatic test_stack_range();
    do_reset();
    drive_call(9'd2, 8'd4, 8'd0, 1'b0, 16'h1, 16'h2);
    #2;
    checks++; if ({bus.call_ack, bus.st_call} !== 2'b00) begin
      failures++; $display("FAIL under_ack got %b want 00", {bus.call_ack, bus.st_call}); end
    step(); idle_inputs(); #2;
    checks++; if (bus.trap_code !== 2'd3) begin failures++; $display("FAIL under_code got %0d want 3", bus.trap_code); end
    do_reset();
    drive_call(9'd250, 8'd0, 8'd6, 1'b0, 16'h1, 16'h2);
    #2;
    checks++; if (bus.call_ack !== 1'b1) begin failures++; $display("FAIL fit_exact_ack got %b want 1", bus.call_ack); end
    step(); idle_inputs();
    wait_ready();
    drive_call(9'd250, 8'd0, 8'd10, 1'b0, 16'h1, 16'h2);
    #1;
    checks++; if (bus.call_ack !== 1'b0) begin failures++; $display("FAIL over_ack got %b want 0", bus.call_ack); end
    step(); idle_inputs(); #2;
    checks++; if (bus.trap_code !== 2'd3) begin failures++; $display("FAIL over_code got %0d want 3", bus.trap_code); end
    checks++; if (bus.frame_cnt !== 5'd1) begin failures++; $display("FAIL over_frame_cnt got %0d want 1", bus.frame_cnt); end
    do_reset();
    drive_call(9'd256, 8'd0, 8'd0, 1'b0, 16'h1, 16'h2);
    #2;
    checks++; if (bus.call_ack !== 1'b0) begin failures++; $display("FAIL base_full_ack got %b want 0", bus.call_ack); end
    step(); idle_inputs(); #2;
    checks++; if (bus.trap_code !== 2'd3) begin failures++; $display("FAIL base_full_code got %0d want 3", bus.trap_code); end
  endtask

  task automatic test_frame_ovf();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_call(9'd10, 8'd0, 8'd0, 1'b0, 16'(i), 16'h5);
      #2;
      checks++;
      if (bus.call_ack !== (i < 16)) begin
        failures++; $display("FAIL ovf_ack call=%0d got %b want %b", i, bus.call_ack, (i < 16)); end
      step();
    end
    idle_inputs(); #2;
    checks++; if (bus.trap !== 1'b1) begin failures++; $display("FAIL ovf_trap got %b want 1", bus.trap); end
    checks++; if (bus.trap_code !== 2'd1) begin failures++; $display("FAIL ovf_code got %0d want 1", bus.trap_code); end
    checks++; if (bus.frame_cnt !== 5'd16) begin failures++; $display("FAIL ovf_frame_cnt got %0d want 16", bus.frame_cnt); end
    bus.ret_req = 1;
    #1;
    checks++; if (bus.st_return !== 1'b0) begin failures++; $display("FAIL ovf_ret_blocked got %b want 0", bus.st_return); end
    repeat (3) step();
    idle_inputs(); #2;
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_sticky got %b want 0", bus.ready); end
    checks++; if (bus.trap_code !== 2'd1) begin failures++; $display("FAIL ovf_code_sticky got %0d want 1", bus.trap_code); end
  endtask

  task automatic test_reset_mid_zero();
    do_reset();
    drive_call(9'd5, 8'd0, 8'd3, 1'b0, 16'h7, 16'h8);
    step(); idle_inputs();
    step();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %b want 1", bus.ready); end
    checks++; if (bus.frame_cnt !== 5'd0) begin failures++; $display("FAIL midrst_frame_cnt got %0d want 0", bus.frame_cnt); end
    checks++; if (bus.st_local_set !== 1'b0) begin failures++; $display("FAIL midrst_local_set got %b want 0", bus.st_local_set); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_passthrough();
    test_call_zero();
    test_return();
    test_back_to_back();
    test_ret_empty();
    test_stack_range();
    test_frame_ovf();
    test_reset_mid_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
